// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operation sequencer: opcode values,
// one-hot function bit positions, FSM state encoding and default widths.
package alu_seq_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int FN_W_DEF   = 11;
  localparam int OP_W_DEF   = 4;

  localparam logic [OP_W_DEF-1:0] OP_LOAD = 4'd0;
  localparam logic [OP_W_DEF-1:0] OP_ADD  = 4'd1;
  localparam logic [OP_W_DEF-1:0] OP_SUB  = 4'd2;
  localparam logic [OP_W_DEF-1:0] OP_MPY  = 4'd3;
  localparam logic [OP_W_DEF-1:0] OP_DIV  = 4'd4;
  localparam logic [OP_W_DEF-1:0] OP_AND  = 4'd5;
  localparam logic [OP_W_DEF-1:0] OP_OR   = 4'd6;
  localparam logic [OP_W_DEF-1:0] OP_NOT  = 4'd7;
  localparam logic [OP_W_DEF-1:0] OP_SHR  = 4'd8;
  localparam logic [OP_W_DEF-1:0] OP_SHL  = 4'd9;
  localparam logic [OP_W_DEF-1:0] OP_NOTA = 4'd10;

  localparam int FN_LOAD = 0;
  localparam int FN_ADD  = 1;
  localparam int FN_SUB  = 2;
  localparam int FN_MPY  = 3;
  localparam int FN_DIV  = 4;
  localparam int FN_AND  = 5;
  localparam int FN_OR   = 6;
  localparam int FN_NOT  = 7;
  localparam int FN_SHR  = 8;
  localparam int FN_SHL  = 9;
  localparam int FN_NOTA = 10;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    DIV_HOLD = 2'd2,
    WB       = 2'd3
  } state_t;

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational opcode decoder: one-hot ALU function, x/y gate enables and
// the writeback/sequencing attributes of each operation.
module alu_op_decoder
  import alu_seq_pkg::*;
#(
  parameter int OP_W = OP_W_DEF,
  parameter int FN_W = FN_W_DEF
) (
  input  logic [OP_W-1:0] opcode,
  output logic [FN_W-1:0] fn,
  output logic            c7,
  output logic            c14,
  output logic            writes_mr,
  output logic            is_div,
  output logic            illegal
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    fn        = '0;
    c7        = 1'b0;
    c14       = 1'b0;
    writes_mr = 1'b0;
    is_div    = 1'b0;
    illegal   = (opcode > OP_NOTA);

    if (!illegal) begin
      fn = FN_W'(1) << opcode;
    end

    case (opcode)
      OP_LOAD: c14 = 1'b1;
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        c7  = 1'b1;
        c14 = 1'b1;
      end
      OP_MPY: begin
        c7        = 1'b1;
        c14       = 1'b1;
        writes_mr = 1'b1;
      end
      OP_DIV: begin
        c7     = 1'b1;
        c14    = 1'b1;
        is_div = 1'b1;
      end
      OP_NOT:          c14       = 1'b1;
      OP_SHR, OP_SHL:  writes_mr = 1'b1;
      OP_NOTA:         c7        = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Issues one ALU operation per request and writes the result back into ACC/MR.
// Optional feature: define DIV0_TRAP_EN to trap divide-by-zero without issuing it.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int FN_W   = FN_W_DEF,
  parameter int OP_W   = OP_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [OP_W-1:0]   opcode,
  input  logic [DATA_W-1:0] operand,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] alu_mr,
  output logic [FN_W-1:0]   fn,
  output logic              c7,
  output logic              c14,
  output logic [DATA_W-1:0] alu_x,
  output logic [DATA_W-1:0] acc,
  output logic [DATA_W-1:0] mr,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t          state, state_nxt;
  logic [OP_W-1:0] op_q;
  logic            err_q;

  logic [FN_W-1:0] dec_fn;
  logic            dec_c7, dec_c14, dec_writes_mr, dec_is_div, dec_illegal;
  logic            illegal_in, trap_in;

  alu_op_decoder #(.OP_W(OP_W), .FN_W(FN_W)) u_dec (
    .opcode    (op_q),
    .fn        (dec_fn),
    .c7        (dec_c7),
    .c14       (dec_c14),
    .writes_mr (dec_writes_mr),
    .is_div    (dec_is_div),
    .illegal   (dec_illegal)
  );

  // Request attributes judged at acceptance time, before op_q is loaded.
  always_comb begin
    illegal_in = (opcode > OP_NOTA);
    trap_in    = 1'b0;
`ifdef DIV0_TRAP_EN
    trap_in    = (opcode == OP_DIV) && (operand == '0);
`else
    trap_in    = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start) state_nxt = trap_in ? WB : ISSUE;
      ISSUE:    state_nxt = dec_is_div ? DIV_HOLD : WB;
      DIV_HOLD: state_nxt = WB;
      WB:       state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // The ALU is only driven while an operation is in flight.
  always_comb begin
    fn   = '0;
    c7   = 1'b0;
    c14  = 1'b0;
    if (state == ISSUE || state == DIV_HOLD) begin
      fn  = dec_fn;
      c7  = dec_c7;
      c14 = dec_c14;
    end
    busy = (state != IDLE);
    done = (state == WB);
    err  = done && err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= '0;
      alu_x <= '0;
      acc   <= '0;
      mr    <= '0;
      err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          op_q  <= opcode;
          alu_x <= operand;
          err_q <= illegal_in || trap_in;
        end
        ISSUE: if (!dec_illegal && !dec_is_div) begin
          acc <= alu_result;
          if (dec_writes_mr) mr <= alu_mr;
        end
        // Quotient was formed on the ISSUE negedge; it is stable by now.
        DIV_HOLD: acc <= alu_result;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench: behavioural ALU plus an arithmetic reference model,
// directed corner cases followed by randomized operation sequences.
module tb_alu_op_sequencer;

`ifdef DIV0_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  opcode;
  logic [15:0] operand;
  logic [15:0] alu_result;
  logic [15:0] alu_mr;
  logic [10:0] fn;
  logic        c7, c14;
  logic [15:0] alu_x, acc, mr;
  logic        busy, done, err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] acc_m = '0;
  logic [15:0] mr_m  = '0;

  always #5 clk = ~clk;

  alu_op_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .opcode     (opcode),
    .operand    (operand),
    .alu_result (alu_result),
    .alu_mr     (alu_mr),
    .fn         (fn),
    .c7         (c7),
    .c14        (c14),
    .alu_x      (alu_x),
    .acc        (acc),
    .mr         (mr),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  // Behavioural ALU: gated x/y inputs, divide registered on the falling edge.
  logic [15:0] x_g, y_g, div_q;
  logic [31:0] wide;
  assign x_g = c7  ? acc   : 16'h0;
  assign y_g = c14 ? alu_x : 16'h0;

  always @(negedge clk) begin
    if (fn[4]) div_q <= (y_g == 16'h0) ? 16'hFFFF : x_g / y_g;
  end

  always_comb begin
    alu_result = 16'h0;
    alu_mr     = 16'h0;
    wide       = 32'h0;
    case (fn)
      11'h001: alu_result = y_g;
      11'h002: alu_result = x_g + y_g;
      11'h004: alu_result = x_g - y_g;
      11'h008: begin wide = 32'(x_g) * 32'(y_g); {alu_mr, alu_result} = wide; end
      11'h010: alu_result = div_q;
      11'h020: alu_result = x_g & y_g;
      11'h040: alu_result = x_g | y_g;
      11'h080: alu_result = ~y_g;
      11'h100: begin wide = {mr, acc} >> 1; {alu_mr, alu_result} = wide; end
      11'h200: begin wide = {mr, acc} << 1; {alu_mr, alu_result} = wide; end
      11'h400: alu_result = ~x_g;
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: effect of one request on ACC/MR plus its expected timing.
  task automatic ref_op(input logic [3:0] op, input logic [15:0] y,
                        output int lat, output bit er, output logic [10:0] fne,
                        output int fnc, output bit e7, output bit e14);
    logic [31:0] w;
    lat = 2;
    er  = 1'b0;
    fnc = 1;
    fne = (op <= 4'd10) ? (11'd1 << op) : 11'd0;
    e7  = op inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd10};
    e14 = op <= 4'd7;
    case (op)
      4'd0: acc_m = y;
      4'd1: acc_m = acc_m + y;
      4'd2: acc_m = acc_m - y;
      4'd3: begin w = 32'(acc_m) * 32'(y); {mr_m, acc_m} = w; end
      4'd4: begin
        if (TRAP && y == 16'h0) begin
          er = 1'b1; lat = 1; fnc = 0; fne = 11'd0;
        end else begin
          lat = 3; fnc = 2;
          acc_m = (y == 16'h0) ? 16'hFFFF : acc_m / y;
        end
      end
      4'd5: acc_m = acc_m & y;
      4'd6: acc_m = acc_m | y;
      4'd7: acc_m = ~y;
      4'd8: begin w = {mr_m, acc_m} >> 1; {mr_m, acc_m} = w; end
      4'd9: begin w = {mr_m, acc_m} << 1; {mr_m, acc_m} = w; end
      4'd10: acc_m = ~acc_m;
      default: begin er = 1'b1; fnc = 0; fne = 11'd0; end
    endcase
  endtask

  // One request; with poke set, start stays high (new random op) while busy and in WB.
  task automatic do_op(input logic [3:0] op, input logic [15:0] y, input bit poke);
    int          exp_lat, exp_fnc, lat, fn_cyc;
    bit          exp_err, e7, e14, got_done, err_seen, bad_fn, busy_bad;
    logic [10:0] fne;
    ref_op(op, y, exp_lat, exp_err, fne, exp_fnc, e7, e14);
    @(negedge clk);
    start = 1'b1; opcode = op; operand = y;
    @(posedge clk);
    lat = 0; fn_cyc = 0; got_done = 0; err_seen = 0; bad_fn = 0; busy_bad = 0;
    for (int cyc = 1; cyc <= 6 && !got_done; cyc++) begin
      @(negedge clk);
      if (poke) begin
        start = 1'b1; opcode = 4'($urandom_range(0, 10)); operand = 16'($urandom);
      end else begin
        start = 1'b0;
      end
      if (fn != 11'h0) begin
        fn_cyc++;
        if (fn != fne || c7 != e7 || c14 != e14) bad_fn = 1;
      end else if (c7 || c14) begin
        bad_fn = 1;
      end
      if (done) begin
        got_done = 1; lat = cyc; err_seen = err;
      end else if (!busy) begin
        busy_bad = 1;
      end
    end
    if (poke) begin
      @(posedge clk);
      #1 start = 1'b0;
    end
    check("latency", lat, exp_lat);
    check("err", 32'(err_seen), 32'(exp_err));
    check("acc", 32'(acc), 32'(acc_m));
    check("mr", 32'(mr), 32'(mr_m));
    check("fn_cycles", fn_cyc, exp_fnc);
    check("fn_gates", 32'(bad_fn), 32'd0);
    check("busy_in_flight", 32'(busy_bad), 32'd0);
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd0);
    check("idle_after", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [3:0]  r_op;
    logic [15:0] r_y;
    bit          done_seen;

    rst_n = 1'b0; start = 1'b0; opcode = 4'h0; operand = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_fn", 32'(fn), 32'd0);
    check("rst_gates", 32'({c7, c14}), 32'd0);
    check("rst_alu_x", 32'(alu_x), 32'd0);
    check("rst_acc", 32'(acc), 32'd0);
    check("rst_mr", 32'(mr), 32'd0);
    check("rst_flags", 32'({busy, done, err}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed corner cases.
    do_op(4'd0, 16'd5, 0);
    do_op(4'd1, 16'd3, 0);
    check("load_add_acc", 32'(acc), 32'h0008);
    do_op(4'd0, 16'h0100, 0);
    do_op(4'd3, 16'h0100, 0);
    check("mpy_mr", 32'(mr), 32'h0001);
    do_op(4'd0, 16'd100, 0);
    do_op(4'd4, 16'd7, 1);
    check("div_acc", 32'(acc), 32'd14);
    do_op(4'hC, 16'h1234, 1);
    do_op(4'd4, 16'd0, 0);

    // Asynchronous reset while the divide is being held.
    do_op(4'd0, 16'h0077, 0);
    @(negedge clk);
    start = 1'b1; opcode = 4'd4; operand = 16'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_fn", 32'(fn), 32'd0);
    check("mid_rst_acc", 32'(acc), 32'd0);
    check("mid_rst_mr", 32'(mr), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    done_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) done_seen = 1;
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (done) done_seen = 1;
    end
    check("mid_rst_no_done", 32'(done_seen), 32'd0);
    acc_m = '0;
    mr_m  = '0;

    // Randomized sequences, biased towards legal ops and zero divisors.
    for (int i = 0; i < 250; i++) begin
      r_op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(11, 15)) : 4'($urandom_range(0, 10));
      r_y  = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      if (r_op == 4'd4 && $urandom_range(0, 1) == 1) r_y = 16'($urandom_range(1, 20));
      do_op(r_op, r_y, $urandom_range(0, 3) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
